// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - IF/data arbiter for one single-ported multi-cycle memory
// Data wins ties unless IF has been passed over MAX_DPRIO times; flushed fetches complete silently.
module mem_port_arbiter #(
   parameter int ADDR_W    = 32,
   parameter int DATA_W    = 32,
   parameter int MEM_LAT   = 2,
   parameter int MAX_DPRIO = 4
) (
   input  logic                i_clk,
   input  logic                i_rst,
   input  logic                i_if_req,
   input  logic [ADDR_W-1:0]   i_if_addr,
   output logic [DATA_W-1:0]   o_if_rdata,
   output logic                o_if_ready,
   input  logic                i_d_req,
   input  logic                i_d_we,
   input  logic [DATA_W/8-1:0] i_d_be,
   input  logic [ADDR_W-1:0]   i_d_addr,
   input  logic [DATA_W-1:0]   i_d_wdata,
   output logic [DATA_W-1:0]   o_d_rdata,
   output logic                o_d_ready,
   input  logic                i_flush,
   output logic                o_mem_en,
   output logic                o_mem_we,
   output logic [DATA_W/8-1:0] o_mem_be,
   output logic [ADDR_W-1:0]   o_mem_addr,
   output logic [DATA_W-1:0]   o_mem_wdata,
   input  logic [DATA_W-1:0]   i_mem_rdata,
   output logic                o_stall_if,
   output logic                o_stall_mem,
   output logic                o_busy
);

   localparam int CNT_W  = $clog2(MEM_LAT + 1);
   localparam int DCNT_W = $clog2(MAX_DPRIO + 1);
   localparam logic [CNT_W-1:0]  CNT_INIT  = CNT_W'(MEM_LAT);
   localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
   localparam logic [DCNT_W-1:0] DCNT_MAX  = DCNT_W'(MAX_DPRIO);
   localparam logic [DCNT_W-1:0] DCNT_ONE  = DCNT_W'(1);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_ISSUE = 2'd1;
   localparam logic [1:0] S_WAIT  = 2'd2;
   localparam logic [1:0] S_RESP  = 2'd3;

   logic [1:0]        r_state;
   logic [CNT_W-1:0]  r_cnt;
   logic [DCNT_W-1:0] r_dcnt;
   logic              r_drop;
   logic              r_grant_d;
   logic [DATA_W-1:0] r_rdata;

   logic w_grant;
   logic w_grant_d;
   logic w_if_starved;
   logic w_issue;
   logic w_issue_d;
   logic w_capture;
   logic w_if_active;
   logic w_if_ready;
   logic w_d_ready;

   assign w_if_starved = (r_dcnt == DCNT_MAX) && i_if_req;

   // RESP hands the port straight to the other requester so neither side starves.
   always_comb begin
      w_grant   = 1'b0;
      w_grant_d = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (i_d_req || i_if_req) begin
               w_grant   = 1'b1;
               w_grant_d = i_d_req && !w_if_starved;
            end
         end
         S_RESP: begin
            if (r_grant_d ? i_if_req : i_d_req) begin
               w_grant   = 1'b1;
               w_grant_d = !r_grant_d;
            end
         end
         default: ;
      endcase
   end

   assign w_issue     = (r_state == S_ISSUE);
   assign w_issue_d   = w_issue && r_grant_d;
   assign w_capture   = (r_state == S_WAIT) && (r_cnt == CNT_ONE) && !(r_grant_d && i_d_we);
   assign w_if_active = ((r_state == S_ISSUE) || (r_state == S_WAIT)) && !r_grant_d;
   assign w_if_ready  = (r_state == S_RESP) && !r_grant_d && !r_drop;
   assign w_d_ready   = (r_state == S_RESP) && r_grant_d;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state   <= S_IDLE;
         r_cnt     <= '0;
         r_dcnt    <= '0;
         r_drop    <= 1'b0;
         r_grant_d <= 1'b0;
         r_rdata   <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_grant) r_state <= S_ISSUE;
            end
            S_ISSUE: begin
               r_cnt   <= CNT_INIT;
               r_state <= S_WAIT;
            end
            S_WAIT: begin
               r_cnt <= r_cnt - CNT_ONE;
               if (r_cnt == CNT_ONE) r_state <= S_RESP;
            end
            default: begin
               r_state <= w_grant ? S_ISSUE : S_IDLE;
            end
         endcase

         if (w_grant) begin
            r_grant_d <= w_grant_d;
            if (w_grant_d) begin
               if (r_dcnt != DCNT_MAX) r_dcnt <= r_dcnt + DCNT_ONE;
            end else begin
               r_dcnt <= '0;
            end
         end

         // A new grant overrides the RESP-exit clear so a flush on a fresh IF grant is not lost.
         if (w_grant)
            r_drop <= !w_grant_d && i_flush;
         else if (r_state == S_RESP)
            r_drop <= 1'b0;
         else if (w_if_active && i_flush)
            r_drop <= 1'b1;

         if (w_capture) r_rdata <= i_mem_rdata;
      end
   end

   assign o_mem_en    = w_issue;
   assign o_mem_we    = w_issue_d && i_d_we;
   assign o_mem_be    = w_issue_d ? i_d_be : (w_issue ? '1 : '0);
   assign o_mem_addr  = w_issue ? (r_grant_d ? i_d_addr : i_if_addr) : '0;
   assign o_mem_wdata = w_issue_d ? i_d_wdata : '0;

   assign o_if_rdata  = r_rdata;
   assign o_d_rdata   = r_rdata;
   assign o_if_ready  = w_if_ready;
   assign o_d_ready   = w_d_ready;
   assign o_stall_if  = i_if_req && !w_if_ready && !i_rst;
   assign o_stall_mem = i_d_req && !w_d_ready && !i_rst;
   assign o_busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed scoreboard bench for mem_port_arbiter
// Expected completions are queued at request time and popped by a negedge monitor.
module tb_mem_port_arbiter;

   localparam int LAT = 2;
   localparam int RL  = LAT + 2;

   typedef struct {
      string       tag;
      logic [31:0] data;
      int          due;
   } exp_t;

   logic        clk, rst;
   logic        if_req, if_ready, d_req, d_we, d_ready, flush;
   logic [31:0] if_addr, if_rdata, d_addr, d_wdata, d_rdata;
   logic [3:0]  d_be, mem_be;
   logic        mem_en, mem_we, stall_if, stall_mem, busy;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;

   int   total = 0;
   int   bad   = 0;
   int   cyc   = 0;
   exp_t if_q[$];
   exp_t d_q[$];
   logic [31:0] last_rd = '0;

   logic [31:0] mem_m [logic [31:0]];
   logic [31:0] rd_pipe [LAT];
   logic        vld_pipe [LAT];

   mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(LAT), .MAX_DPRIO(4)) dut (
      .i_clk(clk), .i_rst(rst),
      .i_if_req(if_req), .i_if_addr(if_addr), .o_if_rdata(if_rdata), .o_if_ready(if_ready),
      .i_d_req(d_req), .i_d_we(d_we), .i_d_be(d_be), .i_d_addr(d_addr), .i_d_wdata(d_wdata),
      .o_d_rdata(d_rdata), .o_d_ready(d_ready), .i_flush(flush),
      .o_mem_en(mem_en), .o_mem_we(mem_we), .o_mem_be(mem_be), .o_mem_addr(mem_addr),
      .o_mem_wdata(mem_wdata), .i_mem_rdata(mem_rdata),
      .o_stall_if(stall_if), .o_stall_mem(stall_mem), .o_busy(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [31:0] hv(input logic [31:0] a);
      return (a * 32'h9E3779B1) ^ 32'h5A5A5A5A;
   endfunction

   function automatic logic [31:0] mem_rd(input logic [31:0] a);
      if (mem_m.exists(a)) return mem_m[a];
      return hv(a);
   endfunction

   // Memory model: read data is only valid exactly LAT cycles after the strobe.
   always @(posedge clk) begin
      logic [31:0] w;
      if (mem_en && mem_we) begin
         w = mem_rd(mem_addr);
         for (int b = 0; b < 4; b++)
            if (mem_be[b]) w[8*b +: 8] = mem_wdata[8*b +: 8];
         mem_m[mem_addr] = w;
      end
      vld_pipe[0] <= mem_en && !mem_we;
      rd_pipe[0]  <= mem_rd(mem_addr);
      for (int i = 1; i < LAT; i++) begin
         vld_pipe[i] <= vld_pipe[i-1];
         rd_pipe[i]  <= rd_pipe[i-1];
      end
   end
   assign mem_rdata = vld_pipe[LAT-1] ? rd_pipe[LAT-1] : 32'hBAD0BAD0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (if_ready === 1'b1) begin
         if (if_q.size() == 0) chk("if_ready_unexpected", 32'd1, 32'd0);
         else begin
            e = if_q.pop_front();
            chk({e.tag, "_data"}, if_rdata, e.data);
            chk({e.tag, "_cycle"}, cyc, e.due);
         end
      end
      if (d_ready === 1'b1) begin
         if (d_q.size() == 0) chk("d_ready_unexpected", 32'd1, 32'd0);
         else begin
            e = d_q.pop_front();
            chk({e.tag, "_data"}, d_rdata, e.data);
            chk({e.tag, "_cycle"}, cyc, e.due);
         end
      end
   end

   task automatic push_exp(input bit is_d, input string tag, input logic [31:0] data, input int due);
      exp_t e;
      e.tag = tag; e.data = data; e.due = due;
      if (is_d) d_q.push_back(e); else if_q.push_back(e);
   endtask

   task automatic do_single(input bit is_d, input logic [31:0] addr, input logic [31:0] exp_data,
                            input string tag);
      int n;
      bit got;
      @(posedge clk); #1;
      push_exp(is_d, tag, exp_data, cyc + RL);
      if (is_d) begin d_req = 1; d_we = 0; d_be = 4'hF; d_addr = addr; end
      else begin if_req = 1; if_addr = addr; end
      last_rd = exp_data;
      n = 0; got = 0;
      while (!got && n < 20) begin
         @(negedge clk); n++;
         got = is_d ? d_ready : if_ready;
      end
      if (!got) chk({tag, "_timeout"}, 32'd0, 32'd1);
      @(posedge clk); #1;
      d_req = 0; if_req = 0;
   endtask

   task automatic do_tie(input bit if_first, input logic [31:0] da, input logic [31:0] ia, input string tag);
      logic [31:0] dd, id;
      int c0;
      @(posedge clk); #1;
      c0 = cyc;
      dd = mem_rd(da); id = mem_rd(ia);
      d_req = 1; d_we = 0; d_be = 4'hF; d_addr = da;
      if_req = 1; if_addr = ia;
      push_exp(1'b0, {tag, "_if"}, id, c0 + (if_first ? RL : 2*RL));
      push_exp(1'b1, {tag, "_d"},  dd, c0 + (if_first ? 2*RL : RL));
      last_rd = if_first ? dd : id;
      for (int k = 0; k <= 2*RL; k++) begin
         @(negedge clk);
         if (k == 1) chk({tag, "_first_addr"}, mem_addr, if_first ? ia : da);
         if (k == RL + 1) begin
            chk({tag, "_second_en"}, {31'd0, mem_en}, 32'd1);
            chk({tag, "_second_addr"}, mem_addr, if_first ? da : ia);
         end
         @(posedge clk); #1;
         if (k == RL) begin if (if_first) if_req = 0; else d_req = 0; end
         if (k == 2*RL) begin d_req = 0; if_req = 0; end
      end
   endtask

   initial begin
      logic [31:0] wexp;
      int n;
      rst = 1; if_req = 0; if_addr = 0; d_req = 0; d_we = 0; d_be = 0;
      d_addr = 0; d_wdata = 0; flush = 0;
      for (int i = 0; i < LAT; i++) begin vld_pipe[i] = 0; rd_pipe[i] = 0; end
      mem_m[32'h100] = 32'h2402000A;
      mem_m[32'h200] = 32'h8C220004;

      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_mem_en", {31'd0, mem_en}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_ready", {30'd0, if_ready, d_ready}, 32'd0);
      chk("rst_rdata", d_rdata, 32'd0);
      @(posedge clk); #1;
      rst = 0;

      // Single fetch: strobe in cycle 1, stall through cycle 3, ready in cycle 4.
      @(posedge clk); #1;
      if_req = 1; if_addr = 32'h100;
      push_exp(1'b0, "fetch100", 32'h2402000A, cyc + RL);
      for (int k = 0; k <= RL; k++) begin
         @(negedge clk);
         chk($sformatf("fetch_stall_c%0d", k), {31'd0, stall_if}, (k < RL) ? 32'd1 : 32'd0);
         chk($sformatf("fetch_en_c%0d", k), {31'd0, mem_en}, (k == 1) ? 32'd1 : 32'd0);
         if (k == 1) chk("fetch_addr", mem_addr, 32'h100);
         @(posedge clk); #1;
         if (k == RL) if_req = 0;
      end

      do_tie(1'b0, 32'h40, 32'h104, "tie_d0");

      // Starvation limit: four data grants in a row, then IF must win the tie.
      do_single(1'b0, 32'h108, mem_rd(32'h108), "clr_dcnt");
      for (int i = 0; i < 4; i++)
         do_single(1'b1, 32'h300 + 4*i, mem_rd(32'h300 + 4*i), $sformatf("dburst%0d", i));
      do_tie(1'b1, 32'h400, 32'h500, "tie_dcnt4");
      for (int i = 0; i < 2; i++)
         do_single(1'b1, 32'h310 + 4*i, mem_rd(32'h310 + 4*i), $sformatf("dpair%0d", i));
      do_tie(1'b0, 32'h404, 32'h504, "tie_dcnt3");

      // Flush during IF wait: memory still strobed, no ready.
      @(posedge clk); #1;
      if_req = 1; if_addr = 32'h180;
      for (int k = 0; k <= RL + 1; k++) begin
         @(negedge clk);
         chk($sformatf("flush_wait_noready_c%0d", k), {31'd0, if_ready}, 32'd0);
         if (k == 1) chk("flush_wait_mem_en", {31'd0, mem_en}, 32'd1);
         @(posedge clk); #1;
         if (k == 1) flush = 1;
         if (k == 2) flush = 0;
         if (k == RL) if_req = 0;
      end
      do_single(1'b0, 32'h200, 32'h8C220004, "fetch200");

      // Flush on the same edge as the IF grant.
      @(posedge clk); #1;
      if_req = 1; if_addr = 32'h204; flush = 1;
      for (int k = 0; k <= RL + 1; k++) begin
         @(negedge clk);
         chk($sformatf("flush_grant_noready_c%0d", k), {31'd0, if_ready}, 32'd0);
         @(posedge clk); #1;
         if (k == 0) flush = 0;
         if (k == RL) if_req = 0;
      end
      @(posedge clk); #1;
      flush = 1;
      @(posedge clk); #1;
      flush = 0;
      do_single(1'b0, 32'h208, mem_rd(32'h208), "fetch208");

      // Flush does not touch data accesses.
      @(posedge clk); #1;
      d_req = 1; d_we = 0; d_be = 4'hF; d_addr = 32'h48;
      push_exp(1'b1, "dflush", mem_rd(32'h48), cyc + RL);
      last_rd = mem_rd(32'h48);
      for (int k = 0; k <= RL; k++) begin
         @(negedge clk);
         @(posedge clk); #1;
         if (k == 1) flush = 1;
         if (k == 2) flush = 0;
         if (k == RL) d_req = 0;
      end

      // Byte-masked write: bus driven only in ISSUE, read data register untouched.
      @(posedge clk); #1;
      d_req = 1; d_we = 1; d_be = 4'b0011; d_addr = 32'h80; d_wdata = 32'hDEADBEEF;
      push_exp(1'b1, "write80", last_rd, cyc + RL);
      for (int k = 0; k <= RL; k++) begin
         @(negedge clk);
         if (k == 1) begin
            chk("wr_en", {31'd0, mem_en}, 32'd1);
            chk("wr_we", {31'd0, mem_we}, 32'd1);
            chk("wr_be", {28'd0, mem_be}, 32'h3);
            chk("wr_addr", mem_addr, 32'h80);
            chk("wr_wdata", mem_wdata, 32'hDEADBEEF);
         end
         if (k == 2) begin
            chk("wr_idle_we", {31'd0, mem_we}, 32'd0);
            chk("wr_idle_wdata", mem_wdata, 32'd0);
            chk("wr_idle_be", {28'd0, mem_be}, 32'd0);
         end
         @(posedge clk); #1;
         if (k == RL) begin d_req = 0; d_we = 0; d_wdata = 0; end
      end
      wexp = hv(32'h80);
      wexp[15:0] = 16'hBEEF;
      do_single(1'b1, 32'h80, wexp, "readback80");

      // Reset during WAIT of a read aborts everything immediately.
      @(posedge clk); #1;
      d_req = 1; d_we = 0; d_be = 4'hF; d_addr = 32'h44;
      @(negedge clk);
      @(negedge clk);
      chk("abort_busy_before", {31'd0, busy}, 32'd1);
      @(posedge clk); #1;
      rst = 1;
      #1;
      chk("abort_busy", {31'd0, busy}, 32'd0);
      chk("abort_mem_en", {31'd0, mem_en}, 32'd0);
      chk("abort_stall_mem", {31'd0, stall_mem}, 32'd0);
      chk("abort_rdata", d_rdata, 32'd0);
      d_req = 0;
      @(posedge clk); #1;
      rst = 0;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         chk($sformatf("post_rst_quiet_c%0d", k), {29'd0, mem_en, d_ready, if_ready}, 32'd0);
      end

      n = 0;
      while ((if_q.size() + d_q.size()) != 0 && n < 50) begin
         @(negedge clk); n++;
      end
      chk("scoreboard_drained", if_q.size() + d_q.size(), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
